// File: rtl/y86_mem_requester.sv
// Memory-stage initiator for the Y86 sequential core: decodes one operation,
// runs a req/gnt/rvalid transaction with timeout, and reports valM and an error flag.
module y86_mem_requester #(
  parameter int unsigned ADDR_LIMIT = 1024,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] valA,
  input  logic [63:0] valE,
  input  logic [63:0] valP,
  output logic        busy,
  output logic        done,
  output logic [63:0] valM,
  output logic        mem_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata
);

  localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_REQ,
    S_RWAIT,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            acc_q, acc_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [63:0]     valm_q, valm_d;
  logic            err_q, err_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [63:0]     addr_q, addr_d;
  logic [63:0]     wdata_q, wdata_d;
  logic            addr_bad_c;
  logic            tmo_c;

  assign addr_bad_c = (addr_q >= 64'(ADDR_LIMIT));
  assign tmo_c      = (cnt_q == CW'(TIMEOUT - 1));

  // Next-state, capture and status logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    valm_d  = valm_q;
    err_d   = err_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CHECK;
          err_d   = 1'b0;
          cnt_d   = '0;
          acc_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = 64'd0;
          wdata_d = 64'd0;
          case (icode)
            4'h4: begin we_d = 1'b1; addr_d = valE; wdata_d = valA; end
            4'h8: begin we_d = 1'b1; addr_d = valE; wdata_d = valP; end
            4'hA: begin we_d = 1'b1; addr_d = valE; wdata_d = valA; end
            4'h5: addr_d = valE;
            4'h9, 4'hB: addr_d = valA;
            default: acc_d = 1'b0;
          endcase
        end
      end
      S_CHECK: begin
        if (!acc_q || addr_bad_c) begin
          state_d = S_DONE;
          err_d   = acc_q;
        end else begin
          state_d = S_REQ;
          cnt_d   = '0;
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          cnt_d = '0;
          if (we_q) begin
            state_d = S_DONE;
            err_d   = 1'b0;
          end else begin
            state_d = S_RWAIT;
          end
        end else if (tmo_c) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RWAIT: begin
        if (mem_rvalid) begin
          state_d = S_DONE;
          valm_d  = mem_rdata;
          err_d   = 1'b0;
        end else if (tmo_c) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs registered from the next state so they align with it
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    req_d  = (state_d == S_REQ);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valm_q  <= 64'd0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valm_q  <= valm_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign valM      = valm_q;
  assign mem_error = err_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_y86_mem_requester.sv
// Bench for y86_mem_requester: directed vector table, randomized ops against a
// transaction-level model, and hand-written reset / start-while-busy sequences.
module tb_y86_mem_requester;

  localparam int unsigned ADDR_LIMIT = 1024;
  localparam int unsigned TIMEOUT    = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  icode = 4'd0;
  logic [63:0] valA = 64'd0, valE = 64'd0, valP = 64'd0;
  logic        busy, done, mem_error, mem_req, mem_we;
  logic [63:0] valM, mem_addr, mem_wdata;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = 64'd0;

  y86_mem_requester #(.ADDR_LIMIT(ADDR_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .icode(icode),
    .valA(valA), .valE(valE), .valP(valP),
    .busy(busy), .done(done), .valM(valM), .mem_error(mem_error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction monitor: request rising edges and done pulses
  int req_rises = 0;
  int done_pulses = 0;
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    if (mem_req && !prev_req) req_rises++;
    if (done) done_pulses++;
    prev_req = mem_req;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  ic;
    logic [63:0] va, ve, vp;
    int          g, r;
    logic [63:0] rd;
    int          lat;
    bit          err, req;
    logic [63:0] addr;
    bit          we;
    logic [63:0] wd;
    logic [63:0] vm;
  } vec_t;

  // Observations of one operation
  int          o_lat;
  bit          o_req, o_we, o_stable, o_err, o_busy_after, o_done_after;
  logic [63:0] o_addr, o_wd, o_valm;

  // Issue one start and play memory: grant after g waiting REQ cycles, rvalid after r RWAIT cycles
  task automatic run_op(input logic [3:0] ic, input logic [63:0] va, ve, vp,
                        input int g, r, input logic [63:0] rd);
    int qcnt = 0, rcnt = 0;
    bit rw = 0, seen = 0;
    o_lat = 0; o_req = 0; o_stable = 1; o_addr = 0; o_we = 0; o_wd = 0;
    o_err = 0; o_valm = 0;
    @(negedge clk);
    start = 1'b1; icode = ic; valA = va; valE = ve; valP = vp;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    start = 1'b0; icode = 4'($urandom);
    valA = {$urandom, $urandom}; valE = {$urandom, $urandom}; valP = {$urandom, $urandom};
    for (int c = 0; c < 200 && !seen; c++) begin
      if (c > 0) @(negedge clk);
      o_lat++;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = {$urandom, $urandom};
      if (done) begin
        seen = 1; o_err = mem_error; o_valm = valM;
      end else if (mem_req) begin
        if (!o_req) begin
          o_req = 1; o_addr = mem_addr; o_we = mem_we; o_wd = mem_wdata;
        end else if (mem_addr !== o_addr || mem_we !== o_we || mem_wdata !== o_wd) begin
          o_stable = 0;
        end
        if (qcnt == g) begin
          mem_gnt = 1'b1;
          if (!mem_we) rw = 1;
        end
        qcnt++;
      end else if (rw) begin
        if (rcnt == r) begin
          mem_rvalid = 1'b1; mem_rdata = rd;
        end
        rcnt++;
      end
    end
    if (!seen) o_lat = -1;
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    o_busy_after = busy; o_done_after = done;
  endtask

  task automatic compare_op(input string tag, input vec_t e);
    check({tag, " latency"}, 64'(o_lat), 64'(e.lat));
    check({tag, " mem_error"}, 64'(o_err), 64'(e.err));
    check({tag, " valM"}, o_valm, e.vm);
    check({tag, " req_seen"}, 64'(o_req), 64'(e.req));
    if (e.req) begin
      check({tag, " mem_addr"}, o_addr, e.addr);
      check({tag, " mem_we"}, 64'(o_we), 64'(e.we));
      check({tag, " req_stable"}, 64'(o_stable), 64'd1);
      if (e.we) check({tag, " mem_wdata"}, o_wd, e.wd);
    end
    check({tag, " busy_after"}, 64'(o_busy_after), 64'd0);
    check({tag, " done_after"}, 64'(o_done_after), 64'd0);
  endtask

  // Transaction-level reference: outcome of one operation from the decode rules and delays
  task automatic ref_op(inout vec_t v);
    bit acc = 1;
    v.we = 0; v.addr = 0; v.wd = 0;
    case (v.ic)
      4'h4, 4'hA: begin v.we = 1; v.addr = v.ve; v.wd = v.va; end
      4'h8:       begin v.we = 1; v.addr = v.ve; v.wd = v.vp; end
      4'h5:       v.addr = v.ve;
      4'h9, 4'hB: v.addr = v.va;
      default:    acc = 0;
    endcase
    v.req = 0; v.err = 0;
    if (!acc) v.lat = 2;
    else if (v.addr >= 64'(ADDR_LIMIT)) begin v.lat = 2; v.err = 1; end
    else begin
      v.req = 1;
      if (v.g >= int'(TIMEOUT)) begin v.lat = 2 + int'(TIMEOUT); v.err = 1; end
      else if (v.we) v.lat = 3 + v.g;
      else if (v.r >= int'(TIMEOUT)) begin v.lat = 3 + v.g + int'(TIMEOUT); v.err = 1; end
      else begin v.lat = 4 + v.g + v.r; v.vm = v.rd; end
    end
  endtask

  vec_t tbl[11];
  logic [63:0] model_vm;

  initial begin
    //        ic     va               ve                       vp       g   r   rd                      lat err req addr      we wd        vm
    tbl[0]  = '{4'h4, 64'hDEAD, 64'd16, 64'd0, 0, 0, 64'd0, 3, 1'b0, 1'b1, 64'd16, 1'b1, 64'hDEAD, 64'd0};
    tbl[1]  = '{4'hB, 64'd8, 64'd99, 64'd0, 2, 2, 64'h1234, 8, 1'b0, 1'b1, 64'd8, 1'b0, 64'd0, 64'h1234};
    tbl[2]  = '{4'h8, 64'd0, 64'd1024, 64'h40, 0, 0, 64'd0, 2, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 64'h1234};
    tbl[3]  = '{4'h1, 64'd5, 64'd6, 64'd7, 0, 0, 64'd0, 2, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 64'h1234};
    tbl[4]  = '{4'h5, 64'd0, 64'd4, 64'd0, 99, 0, 64'hFFFF, 17, 1'b1, 1'b1, 64'd4, 1'b0, 64'd0, 64'h1234};
    tbl[5]  = '{4'h5, 64'd0, 64'd1023, 64'd0, 0, 99, 64'hFFFF, 18, 1'b1, 1'b1, 64'd1023, 1'b0, 64'd0, 64'h1234};
    tbl[6]  = '{4'hA, 64'd55, 64'd1023, 64'd0, 14, 0, 64'd0, 17, 1'b0, 1'b1, 64'd1023, 1'b1, 64'd55, 64'h1234};
    tbl[7]  = '{4'h9, 64'd1024, 64'd0, 64'd0, 0, 0, 64'd0, 2, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 64'h1234};
    tbl[8]  = '{4'h5, 64'd0, 64'h20, 64'd0, 1, 0, 64'hCAFEF00D, 5, 1'b0, 1'b1, 64'h20, 1'b0, 64'd0, 64'hCAFEF00D};
    tbl[9]  = '{4'h4, 64'd1, 64'hFFFF_FFFF_0000_0010, 64'd0, 0, 0, 64'd0, 2, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 64'hCAFEF00D};
    tbl[10] = '{4'h5, 64'd0, 64'd0, 64'd0, 0, 14, 64'h0BAD_BEEF_0000_0001, 18, 1'b0, 1'b1, 64'd0, 1'b0, 64'd0, 64'h0BAD_BEEF_0000_0001};

    // Reset held with inputs toggling: every output stays 0
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #2;
      start = 1'($urandom); icode = 4'($urandom);
      valA = {$urandom, $urandom}; valE = 64'($urandom_range(0, 64)); valP = {$urandom, $urandom};
      mem_gnt = 1'($urandom); mem_rvalid = 1'($urandom); mem_rdata = {$urandom, $urandom};
      @(negedge clk);
      check("rst busy", 64'(busy), 64'd0);
      check("rst done", 64'(done), 64'd0);
      check("rst valM", valM, 64'd0);
      check("rst mem_error", 64'(mem_error), 64'd0);
      check("rst mem_req", 64'(mem_req), 64'd0);
      check("rst mem_we", 64'(mem_we), 64'd0);
      check("rst mem_addr", mem_addr, 64'd0);
      check("rst mem_wdata", mem_wdata, 64'd0);
    end
    start = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 11; i++) begin
      run_op(tbl[i].ic, tbl[i].va, tbl[i].ve, tbl[i].vp, tbl[i].g, tbl[i].r, tbl[i].rd);
      compare_op($sformatf("vec%0d", i), tbl[i]);
    end
    model_vm = tbl[10].vm;

    // Randomized operations against the reference model
    for (int i = 0; i < 60; i++) begin
      vec_t v;
      v.ic = 4'($urandom);
      if ($urandom_range(0, 2) == 0) v.ic = 4'($urandom_range(8, 11));
      v.va = {$urandom, $urandom}; v.ve = {$urandom, $urandom}; v.vp = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: begin v.va = 64'($urandom_range(0, 1023)); v.ve = 64'($urandom_range(0, 1023)); end
        1: begin v.va = 64'($urandom_range(1023, 1024)); v.ve = 64'($urandom_range(1023, 1024)); end
        2: begin v.va = 64'($urandom_range(1024, 5000)); v.ve = 64'($urandom_range(0, 1023)); end
        default: ;
      endcase
      v.g = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 3);
      v.r = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 3);
      v.rd = {$urandom, $urandom};
      v.vm = model_vm;
      ref_op(v);
      model_vm = v.vm;
      run_op(v.ic, v.va, v.ve, v.vp, v.g, v.r, v.rd);
      compare_op($sformatf("rnd%0d ic%0h", i, v.ic), v);
    end

    // start held during busy and in the DONE cycle: exactly one transaction
    begin
      int r0, d0, q;
      logic [63:0] a_seen;
      r0 = req_rises; d0 = done_pulses; q = 0; a_seen = 64'hX;
      @(negedge clk);
      start = 1'b1; icode = 4'h4; valA = 64'd7; valE = 64'd2;
      for (int c = 0; c < 14; c++) begin
        @(negedge clk);
        mem_gnt = 1'b0;
        if (mem_req) begin
          if (q == 0) a_seen = mem_addr;
          if (q == 2) mem_gnt = 1'b1;
          q++;
        end
        start = busy; icode = 4'h5; valE = 64'd3;
      end
      start = 1'b0; mem_gnt = 1'b0;
      check("busy_start req_count", 64'(req_rises - r0), 64'd1);
      check("busy_start done_count", 64'(done_pulses - d0), 64'd1);
      check("busy_start addr", a_seen, 64'd2);
      check("busy_start req_cycles", 64'(q), 64'd3);
    end

    // Reset asserted during REQ: request drops at once and no done follows
    begin
      int d0;
      @(negedge clk);
      start = 1'b1; icode = 4'h4; valA = 64'd1; valE = 64'd2;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("midrst req_before", 64'(mem_req), 64'd1);
      d0 = done_pulses;
      #2 reset = 1'b1;
      #1;
      check("midrst req_async", 64'(mem_req), 64'd0);
      check("midrst busy_async", 64'(busy), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check("midrst no_done", 64'(done_pulses - d0), 64'd0);
      check("midrst idle", 64'(busy), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
